// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with CDB capture, operand lookup and mispredict flush
module reorder_buffer #(
    parameter int ROB_SIZE   = 8,
    parameter int ID_WIDTH   = 4,
    parameter int VAL_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_en,
    input  logic                  issue_isbr,
    input  logic [REG_WIDTH-1:0]  issue_rd,
    input  logic                  issue_pred,
    input  logic [ADDR_WIDTH-1:0] issue_altpc,
    output logic                  full,
    output logic [ID_WIDTH-1:0]   new_tag,
    input  logic [ID_WIDTH-1:0]   qry1_tag,
    input  logic [ID_WIDTH-1:0]   qry2_tag,
    output logic                  qry1_ready,
    output logic                  qry2_ready,
    output logic [VAL_WIDTH-1:0]  qry1_val,
    output logic [VAL_WIDTH-1:0]  qry2_val,
    input  logic                  cdb_en,
    input  logic [ID_WIDTH-1:0]   cdb_tag,
    input  logic [VAL_WIDTH-1:0]  cdb_val,
    output logic                  commit_en,
    output logic [REG_WIDTH-1:0]  commit_rd,
    output logic [ID_WIDTH-1:0]   commit_tag,
    output logic [VAL_WIDTH-1:0]  commit_val,
    output logic                  flush_out,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;
    logic [ROB_SIZE-1:0]   busy, rdy_q, isbr_q, pred_q;
    logic [REG_WIDTH-1:0]  rd_q    [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] altpc_q [ROB_SIZE];
    logic [VAL_WIDTH-1:0]  val_q   [ROB_SIZE];

    logic             do_issue, do_cdb, do_commit, mispredict;
    logic [IDX_W-1:0] cdb_idx, q1_idx, q2_idx;

    // Tags are entry index + 1; 0 and anything above ROB_SIZE name no entry.
    function automatic logic tag_valid(input logic [ID_WIDTH-1:0] t);
        return (t != '0) && (t <= ID_WIDTH'(ROB_SIZE));
    endfunction

    function automatic logic [IDX_W-1:0] tag_idx(input logic [ID_WIDTH-1:0] t);
        return IDX_W'(t - ID_WIDTH'(1));
    endfunction

    function automatic logic [VAL_WIDTH:0] lookup(
        input logic [ID_WIDTH-1:0]  t,
        input logic                 stored_ok,
        input logic [VAL_WIDTH-1:0] stored,
        input logic                 c_en,
        input logic [ID_WIDTH-1:0]  c_tag,
        input logic [VAL_WIDTH-1:0] c_val
    );
        if (t == '0)                return {1'b1, {VAL_WIDTH{1'b0}}};
        else if (c_en && c_tag == t) return {1'b1, c_val};
        else if (stored_ok)         return {1'b1, stored};
        else                        return '0;
    endfunction

    assign full    = (count == CNT_W'(ROB_SIZE));
    assign new_tag = ID_WIDTH'(tail) + ID_WIDTH'(1);
    assign q1_idx  = tag_idx(qry1_tag);
    assign q2_idx  = tag_idx(qry2_tag);
    assign cdb_idx = tag_idx(cdb_tag);

    assign {qry1_ready, qry1_val} = lookup(qry1_tag,
        tag_valid(qry1_tag) && busy[q1_idx] && rdy_q[q1_idx], val_q[q1_idx],
        cdb_en, cdb_tag, cdb_val);
    assign {qry2_ready, qry2_val} = lookup(qry2_tag,
        tag_valid(qry2_tag) && busy[q2_idx] && rdy_q[q2_idx], val_q[q2_idx],
        cdb_en, cdb_tag, cdb_val);

    // Commit reads the registered ready bit, so a CDB write retires one edge later.
    always_comb begin
        do_commit  = busy[head] && rdy_q[head] && !flush_out;
        mispredict = do_commit && isbr_q[head] && (val_q[head][0] != pred_q[head]);
        do_issue   = issue_en && !full && !flush_out && !mispredict;
        do_cdb     = cdb_en && !flush_out && tag_valid(cdb_tag) && busy[cdb_idx];
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            busy        <= '0;
            rdy_q       <= '0;
            commit_en   <= 1'b0;
            commit_rd   <= '0;
            commit_tag  <= '0;
            commit_val  <= '0;
            flush_out   <= 1'b0;
            redirect_pc <= '0;
        end else if (!rdy_in) begin
            commit_en <= 1'b0;
            flush_out <= 1'b0;
        end else begin
            commit_en <= do_commit;
            flush_out <= mispredict;
            if (do_cdb) begin
                rdy_q[cdb_idx] <= 1'b1;
                val_q[cdb_idx] <= cdb_val;
            end
            if (do_issue) begin
                busy[tail]    <= 1'b1;
                rdy_q[tail]   <= 1'b0;
                isbr_q[tail]  <= issue_isbr;
                pred_q[tail]  <= issue_pred;
                rd_q[tail]    <= issue_rd;
                altpc_q[tail] <= issue_altpc;
                tail          <= tail + IDX_W'(1);
            end
            if (do_commit) begin
                commit_rd  <= isbr_q[head] ? '0 : rd_q[head];
                commit_tag <= ID_WIDTH'(head) + ID_WIDTH'(1);
                commit_val <= val_q[head];
                busy[head] <= 1'b0;
                head       <= head + IDX_W'(1);
            end
            if (mispredict) begin
                redirect_pc <= altpc_q[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                busy        <= '0;
            end else begin
                count <= count + CNT_W'(do_issue) - CNT_W'(do_commit);
            end
        end
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) for the Tomasulo core.
- Downstream of the reservation station: it consumes the CDB broadcasts the RS and ALU produce.
- Upstream of issue: it allocates the tag (`newTag`) that the RS stores per entry, and answers operand queries with ready/value.
- Commits one instruction per cycle to the register file, in program order.
- Raises a pipeline flush when a branch mispredicts.

Parameters:
- ROB_SIZE, 8, number of entries; power of two.
- ID_WIDTH, 4, tag width. Tag = entry index + 1; tag 0 means "no dependency".
- VAL_WIDTH, 32, data width.
- ADDR_WIDTH, 32, PC width.
- REG_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low = hold all state.
- issue_en  in  1  decoder issues one instruction this cycle.
- issue_isbr  in  1  instruction is a conditional branch (no register write).
- issue_rd  in  REG_WIDTH  destination register; 0 = no write.
- issue_pred  in  1  predicted taken.
- issue_altpc  in  ADDR_WIDTH  PC to fetch if the prediction is wrong.
- full  out  1  no free entry; decoder must not issue.
- new_tag  out  ID_WIDTH  tag that the next issue receives (tail+1).
- qry1_tag, qry2_tag  in  ID_WIDTH  operand tags looked up in the register file.
- qry1_ready, qry2_ready  out  1  operand value available.
- qry1_val, qry2_val  out  VAL_WIDTH  operand value.
- cdb_en  in  1  CDB broadcast valid.
- cdb_tag  in  ID_WIDTH  producing tag.
- cdb_val  in  VAL_WIDTH  result. For branches, bit 0 = actual taken.
- commit_en  out  1  registered pulse: head retired.
- commit_rd  out  REG_WIDTH  register to write.
- commit_tag  out  ID_WIDTH  retired tag; the register file clears its label if it still matches.
- commit_val  out  VAL_WIDTH  value to write.
- flush_out  out  1  registered one-cycle pulse: mispredict, clear the pipeline.
- redirect_pc  out  ADDR_WIDTH  fetch target; valid while flush_out is high.

Behaviour:

Reset (synchronous, rst_in high at a clk edge):
- head = tail = 0, count = 0, all busy/ready bits cleared.
- commit_en = 0, commit_rd = 0, commit_tag = 0, commit_val = 0.
- flush_out = 0, redirect_pc = 0.
- full = 0, new_tag = 1.
- Reset overrides every other input.

rdy_in low:
- No state changes.
- commit_en and flush_out are forced to 0 at that edge.

Combinational outputs:
- full = (count == ROB_SIZE).
- new_tag = tail + 1.

Operand query (combinational), evaluated in this order:
1. Tag 0 → ready = 1, val = 0.
2. cdb_en with cdb_tag == qry_tag → ready = 1, val = cdb_val (same-cycle bypass).
3. Entry busy and ready → stored value.
4. Otherwise ready = 0, val = 0.

Issue (issue_en && !full && !flush_out):
- Write entry[tail]: busy = 1, ready = 0, isbr, rd, pred, altpc.
- tail = (tail + 1) mod ROB_SIZE.
- issue_en while full is ignored.

CDB writeback (cdb_en && !flush_out, busy entry with index cdb_tag − 1):
- Set ready = 1 and value = cdb_val.
- A broadcast to a non-busy tag, or to tag 0, is ignored.

Commit (head busy && head ready && !flush_out):
- Latency: an entry made ready by the CDB at edge N can commit at edge N+1 at the earliest.
- Next edge registers commit_en = 1, commit_tag = head + 1, commit_val = value.
- commit_rd = rd for non-branches; 0 for branches.
- Clear busy; head = (head + 1) mod ROB_SIZE.

Count update:
- count += issue − commit.
- Issue into a full ROB is not allowed even if a commit occurs in the same cycle.
- Issue into an empty ROB cannot commit in the same cycle.

Mispredict:
- Condition: the committing head is a branch and value[0] != pred.
- At that edge: flush_out = 1, redirect_pc = altpc.
- All entries are cleared at the same edge: head = tail = count = 0.
- Any same-cycle issue is discarded.
- While flush_out = 1: issue, CDB writes and commits are ignored. flush_out falls after one cycle.
- A correctly predicted branch commits with commit_rd = 0 and no flush.

Wrap-around:
- Tags cycle 1..ROB_SIZE.
- After 8 issues and 8 commits, the next tag issued is 1 again.

Test Plan:
- Reset, then issue rd=3, 5, 7 → new_tag steps 1, 2, 3, 4; full = 0. CDB tag 2 = 0x55 then tag 1 = 0x11 → commits in order: (rd 3, tag 1, 0x11), then (rd 5, tag 2, 0x55); tag 3 does not commit until its own CDB write.
- Issue 8 entries → full = 1 and a 9th issue_en is ignored. Make the head ready and issue at the same edge: commit occurs and the issue is rejected; at the next edge issue succeeds with tag 1 (wrap-around).
- qry1_tag = 4 while cdb_en with cdb_tag = 4, cdb_val = 0xDEAD → qry1_ready = 1, qry1_val = 0xDEAD in the same cycle. qry2_tag = 0 → ready = 1, val = 0.
- Branch tag 1 with pred = 1, altpc = 0x100, followed by 2 ALU entries. CDB tag 1 val = 0 → commit pulse has commit_rd = 0, flush_out = 1, redirect_pc = 0x100. Next cycle full = 0, new_tag = 1. A later CDB write for old tag 2 must not create a commit.
- Branch with pred = 0 and CDB val = 0 → commits with no flush.
- Hold rdy_in = 0 for 3 cycles with the head ready → no commit and no state change. Assert rst_in mid-stream → all outputs return to their reset values at the next edge.
